// File: rtl/riscv_hwloop_controller.sv
// Hardware-loop controller: matches the IF-stage PC against every loop end
// address, issues registered jump-to-start requests to fetch and strobes
// one-hot counter decrements into the loop register file. Nested loops that
// share an end address have their decrements serialised, one per cycle.
module riscv_hwloop_controller #(
    parameter int N_REGS     = 2,
    parameter int N_REG_BITS = $clog2(N_REGS)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [31:0]                pc_i,
    input  logic                       pc_valid_i,
    input  logic                       flush_i,
    input  logic [N_REGS-1:0][31:0]    hwlp_start_addr_i,
    input  logic [N_REGS-1:0][31:0]    hwlp_end_addr_i,
    input  logic [N_REGS-1:0][31:0]    hwlp_counter_i,
    input  logic [2:0]                 hwlp_we_i,
    input  logic [N_REG_BITS-1:0]      hwlp_regid_i,
    input  logic                       fetch_ready_i,
    output logic                       hwlp_jump_o,
    output logic [31:0]                hwlp_targ_addr_o,
    output logic [N_REGS-1:0]          hwlp_dec_cnt_o,
    output logic                       hwlp_dec_valid_o,
    output logic                       hwlp_busy_o
);

    typedef enum logic [0:0] {
        IDLE     = 1'b0,
        DEC_PEND = 1'b1
    } state_e;

    state_e                  state_q, state_d;
    logic                    jump_q, jump_d;
    logic [31:0]             targ_q, targ_d;
    logic [N_REG_BITS-1:0]   pend_q, pend_d;

    logic                    busy;
    logic                    eval_en;
    logic [N_REGS-1:0]       hit;
    logic                    found_k, found_j;
    logic [N_REG_BITS-1:0]   k_idx, j_idx;

    // Only the counter-write enable matters here; the other bits are address writes.
    logic                    unused_we;
    assign unused_we = ^hwlp_we_i[1:0];

    assign busy    = jump_q || (state_q == DEC_PEND);
    // Reset is folded in so the Mealy decrement outputs stay quiet while rst_n is low.
    assign eval_en = pc_valid_i && !busy && rst_n;

    // Hit vector and priority pick: k = lowest hit, j = next higher hit.
    always_comb begin
        hit     = '0;
        found_k = 1'b0;
        found_j = 1'b0;
        k_idx   = '0;
        j_idx   = '0;
        for (int i = 0; i < N_REGS; i++) begin
            hit[i] = eval_en && (pc_i == hwlp_end_addr_i[i]) && (hwlp_counter_i[i] != 32'd0);
        end
        // Descending scan: the last hit seen is the lowest, the one before it is j.
        for (int i = N_REGS - 1; i >= 0; i--) begin
            if (hit[i]) begin
                found_j = found_k;
                j_idx   = k_idx;
                found_k = 1'b1;
                k_idx   = N_REG_BITS'(i);
            end
        end
    end

    // Next-state, jump handshake and Mealy decrement outputs.
    always_comb begin
        state_d          = state_q;
        jump_d           = jump_q;
        targ_d           = targ_q;
        pend_d           = pend_q;
        hwlp_dec_cnt_o   = '0;
        hwlp_dec_valid_o = 1'b0;

        if (jump_q && fetch_ready_i) begin
            jump_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (found_k) begin
                    hwlp_dec_cnt_o[k_idx] = 1'b1;
                    hwlp_dec_valid_o      = 1'b1;
                    if (hwlp_counter_i[k_idx] > 32'd1) begin
                        targ_d = hwlp_start_addr_i[k_idx];
                        jump_d = 1'b1;
                    end else if (found_j) begin
                        // Inner loop exits on a shared end address: outer loop decrements next cycle.
                        pend_d  = j_idx;
                        state_d = DEC_PEND;
                        if (hwlp_counter_i[j_idx] > 32'd1) begin
                            targ_d = hwlp_start_addr_i[j_idx];
                            jump_d = 1'b1;
                        end
                    end
                end
            end
            DEC_PEND: begin
                state_d = IDLE;
                // A simultaneous software write to the same counter overrides the decrement.
                if (!(hwlp_we_i[2] && (hwlp_regid_i == pend_q))) begin
                    hwlp_dec_cnt_o[pend_q] = 1'b1;
                    hwlp_dec_valid_o       = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Flush kills the jump request but never the serialised decrement.
        if (flush_i) begin
            jump_d = 1'b0;
        end
    end

    // State, jump request, target and pending index registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            jump_q  <= 1'b0;
            targ_q  <= 32'd0;
            pend_q  <= '0;
        end else begin
            state_q <= state_d;
            jump_q  <= jump_d;
            targ_q  <= targ_d;
            pend_q  <= pend_d;
        end
    end

    assign hwlp_jump_o      = jump_q;
    assign hwlp_targ_addr_o = targ_q;
    assign hwlp_busy_o      = busy;

endmodule

// File: tb/tb_riscv_hwloop_controller.sv
// Bench for riscv_hwloop_controller: directed scenarios followed by a
// randomized run against a queue-based behavioural model.
module tb_riscv_hwloop_controller;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [31:0]       pc;
    logic              pc_valid;
    logic              flush;
    logic [1:0][31:0]  start_a;
    logic [1:0][31:0]  end_a;
    logic [1:0][31:0]  cnt;
    logic [2:0]        we;
    logic [0:0]        regid;
    logic              fetch_ready;
    logic              jump;
    logic [31:0]       targ;
    logic [1:0]        dec_cnt;
    logic              dec_valid;
    logic              busy;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    riscv_hwloop_controller #(.N_REGS(2), .N_REG_BITS(1)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .pc_i              (pc),
        .pc_valid_i        (pc_valid),
        .flush_i           (flush),
        .hwlp_start_addr_i (start_a),
        .hwlp_end_addr_i   (end_a),
        .hwlp_counter_i    (cnt),
        .hwlp_we_i         (we),
        .hwlp_regid_i      (regid),
        .fetch_ready_i     (fetch_ready),
        .hwlp_jump_o       (jump),
        .hwlp_targ_addr_o  (targ),
        .hwlp_dec_cnt_o    (dec_cnt),
        .hwlp_dec_valid_o  (dec_valid),
        .hwlp_busy_o       (busy)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic quiet();
        pc = 32'h0; pc_valid = 1'b0; flush = 1'b0; we = 3'b000; regid = 1'b0;
        fetch_ready = 1'b1; start_a = '0; end_a = '0; cnt = '0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        quiet();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic setup_nested();
        end_a[0] = 32'h100; end_a[1] = 32'h100;
        cnt[0] = 32'd1; cnt[1] = 32'd5;
        start_a[0] = 32'h20; start_a[1] = 32'h40;
        pc = 32'h100;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        quiet();
        cnt[0] = 32'd3; end_a[0] = 32'h100; start_a[0] = 32'h80;
        pc = 32'h100; pc_valid = 1'b1;
        #1;
        total++; if (dec_valid !== 1'b0) begin bad++; $display("FAIL reset_dec_valid got=%0b exp=0", dec_valid); end
        total++; if (dec_cnt !== 2'b00) begin bad++; $display("FAIL reset_dec_cnt got=%b exp=00", dec_cnt); end
        tick();
        total++; if (jump !== 1'b0) begin bad++; $display("FAIL reset_jump got=%0b exp=0", jump); end
        total++; if (targ !== 32'h0) begin bad++; $display("FAIL reset_targ got=%h exp=0", targ); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%0b exp=0", busy); end
        pc_valid = 1'b0;
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_single_jump();
        do_reset();
        cnt[0] = 32'd3; end_a[0] = 32'h100; start_a[0] = 32'h80;
        end_a[1] = 32'h300; cnt[1] = 32'd2;
        pc = 32'h100; pc_valid = 1'b1; fetch_ready = 1'b1;
        #1;
        total++; if (dec_cnt !== 2'b01 || dec_valid !== 1'b1) begin bad++; $display("FAIL jump_dec got=%b/%0b exp=01/1", dec_cnt, dec_valid); end
        total++; if (jump !== 1'b0) begin bad++; $display("FAIL jump_early got=%0b exp=0", jump); end
        tick();
        pc_valid = 1'b0;
        #1;
        total++; if (jump !== 1'b1 || targ !== 32'h80) begin bad++; $display("FAIL jump_set got=%0b/%h exp=1/80", jump, targ); end
        total++; if (busy !== 1'b1 || dec_valid !== 1'b0) begin bad++; $display("FAIL jump_busy got=%0b/%0b exp=1/0", busy, dec_valid); end
        tick();
        total++; if (jump !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL jump_clear got=%0b/%0b exp=0/0", jump, busy); end
    endtask

    task automatic test_loop_exit();
        do_reset();
        cnt[0] = 32'd1; end_a[0] = 32'h100; start_a[0] = 32'h80;
        end_a[1] = 32'h200; cnt[1] = 32'd2; start_a[1] = 32'h10;
        pc = 32'h100; pc_valid = 1'b1;
        #1;
        total++; if (dec_cnt !== 2'b01 || dec_valid !== 1'b1) begin bad++; $display("FAIL exit_dec got=%b/%0b exp=01/1", dec_cnt, dec_valid); end
        tick();
        pc_valid = 1'b0;
        #1;
        total++; if (jump !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL exit_nojump got=%0b/%0b exp=0/0", jump, busy); end
    endtask

    task automatic test_nested();
        do_reset();
        setup_nested();
        pc_valid = 1'b1; fetch_ready = 1'b0;
        #1;
        total++; if (dec_cnt !== 2'b01 || dec_valid !== 1'b1) begin bad++; $display("FAIL nest_dec0 got=%b/%0b exp=01/1", dec_cnt, dec_valid); end
        tick();
        pc_valid = 1'b0;
        #1;
        total++; if (dec_cnt !== 2'b10 || dec_valid !== 1'b1) begin bad++; $display("FAIL nest_dec1 got=%b/%0b exp=10/1", dec_cnt, dec_valid); end
        total++; if (jump !== 1'b1 || targ !== 32'h40 || busy !== 1'b1) begin bad++; $display("FAIL nest_jump got=%0b/%h/%0b exp=1/40/1", jump, targ, busy); end
        tick();
        total++; if (dec_valid !== 1'b0 || dec_cnt !== 2'b00 || jump !== 1'b1) begin bad++; $display("FAIL nest_after got=%0b/%b/%0b exp=0/00/1", dec_valid, dec_cnt, jump); end
        fetch_ready = 1'b1;
        tick();
        total++; if (jump !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL nest_accept got=%0b/%0b exp=0/0", jump, busy); end
    endtask

    task automatic test_stall();
        do_reset();
        cnt[0] = 32'd3; end_a[0] = 32'h100; start_a[0] = 32'h80;
        pc = 32'h100; pc_valid = 1'b1; fetch_ready = 1'b0;
        tick();
        for (int c = 0; c < 4; c++) begin
            #1;
            total++; if (jump !== 1'b1 || targ !== 32'h80 || busy !== 1'b1) begin bad++; $display("FAIL stall_hold c=%0d got=%0b/%h/%0b exp=1/80/1", c, jump, targ, busy); end
            total++; if (dec_valid !== 1'b0) begin bad++; $display("FAIL stall_ignore c=%0d got=%0b exp=0", c, dec_valid); end
            tick();
        end
        pc_valid = 1'b0; fetch_ready = 1'b1;
        tick();
        total++; if (jump !== 1'b0) begin bad++; $display("FAIL stall_accept got=%0b exp=0", jump); end
    endtask

    task automatic test_flush();
        do_reset();
        cnt[0] = 32'd3; end_a[0] = 32'h100; start_a[0] = 32'h80;
        pc = 32'h100; pc_valid = 1'b1; fetch_ready = 1'b0;
        tick();
        pc_valid = 1'b0; flush = 1'b1;
        tick();
        flush = 1'b0;
        total++; if (jump !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL flush_jump got=%0b/%0b exp=0/0", jump, busy); end
        // counter write to the pending loop drops its decrement
        setup_nested();
        pc_valid = 1'b1; fetch_ready = 1'b1;
        tick();
        pc_valid = 1'b0; we = 3'b100; regid = 1'b1;
        #1;
        total++; if (dec_valid !== 1'b0 || dec_cnt !== 2'b00) begin bad++; $display("FAIL write_drop got=%0b/%b exp=0/00", dec_valid, dec_cnt); end
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL write_busy got=%0b exp=1", busy); end
        tick();
        we = 3'b000;
        tick();
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL write_idle got=%0b exp=0", busy); end
        // flush during the pending decrement kills the jump but not the decrement
        pc_valid = 1'b1; fetch_ready = 1'b0;
        tick();
        pc_valid = 1'b0; flush = 1'b1;
        #1;
        total++; if (dec_valid !== 1'b1 || dec_cnt !== 2'b10) begin bad++; $display("FAIL flush_pend got=%0b/%b exp=1/10", dec_valid, dec_cnt); end
        tick();
        flush = 1'b0;
        total++; if (jump !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL flush_pend_jump got=%0b/%0b exp=0/0", jump, busy); end
        fetch_ready = 1'b1;
    endtask

    task automatic test_reset_mid();
        do_reset();
        setup_nested();
        pc_valid = 1'b1; fetch_ready = 1'b0;
        tick();
        pc_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        total++; if (dec_valid !== 1'b0 || dec_cnt !== 2'b00) begin bad++; $display("FAIL rstmid_dec got=%0b/%b exp=0/00", dec_valid, dec_cnt); end
        total++; if (jump !== 1'b0 || busy !== 1'b0 || targ !== 32'h0) begin bad++; $display("FAIL rstmid_jump got=%0b/%0b/%h exp=0/0/0", jump, busy, targ); end
        tick();
        rst_n = 1'b1;
        #1;
        total++; if (dec_valid !== 1'b0 || jump !== 1'b0) begin bad++; $display("FAIL rstrel0 got=%0b/%0b exp=0/0", dec_valid, jump); end
        tick();
        total++; if (dec_valid !== 1'b0 || jump !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL rstrel1 got=%0b/%0b/%0b exp=0/0/0", dec_valid, jump, busy); end
        fetch_ready = 1'b1;
    endtask

    task automatic test_random();
        bit          m_jump;
        logic [31:0] m_targ;
        int          pendq[$];
        int          hits[$];
        logic [1:0]  e_dec;
        bit          e_busy;
        bit          n_jump;
        logic [31:0] n_targ;
        int          idx;
        do_reset();
        m_jump = 1'b0;
        m_targ = 32'h0;
        pendq.delete();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            for (int r = 0; r < 2; r++) begin
                end_a[r]   = ($urandom_range(0, 1) == 0) ? 32'h100 : 32'h200;
                cnt[r]     = 32'($urandom_range(0, 3));
                start_a[r] = 32'($urandom_range(0, 255)) << 2;
            end
            pc          = ($urandom_range(0, 4) == 0) ? 32'h300 : end_a[$urandom_range(0, 1)];
            pc_valid    = ($urandom_range(0, 9) < 7);
            fetch_ready = ($urandom_range(0, 1) == 1);
            flush       = ($urandom_range(0, 9) == 0);
            we          = ($urandom_range(0, 9) < 3) ? 3'b100 : 3'($urandom_range(0, 3));
            regid       = 1'($urandom_range(0, 1));
            #1;
            // expected outputs for this cycle and model state for the next
            e_busy = m_jump || (pendq.size() > 0);
            e_dec  = 2'b00;
            n_jump = m_jump && !fetch_ready;
            n_targ = m_targ;
            if (pendq.size() > 0) begin
                idx = pendq.pop_front();
                if (!(we[2] && int'(regid) == idx)) e_dec = 2'(1 << idx);
            end else if (!e_busy && pc_valid) begin
                hits.delete();
                for (int r = 0; r < 2; r++) if (pc == end_a[r] && cnt[r] != 0) hits.push_back(r);
                if (hits.size() > 0) begin
                    e_dec = 2'(1 << hits[0]);
                    if (cnt[hits[0]] > 1) begin
                        n_jump = 1'b1; n_targ = start_a[hits[0]];
                    end else if (hits.size() > 1) begin
                        pendq.push_back(hits[1]);
                        if (cnt[hits[1]] > 1) begin
                            n_jump = 1'b1; n_targ = start_a[hits[1]];
                        end
                    end
                end
            end
            if (flush) n_jump = 1'b0;
            total++; if (dec_cnt !== e_dec) begin bad++; $display("FAIL rnd_dec_cnt cyc=%0d got=%b exp=%b", cyc, dec_cnt, e_dec); end
            total++; if (dec_valid !== (e_dec != 2'b00)) begin bad++; $display("FAIL rnd_dec_valid cyc=%0d got=%0b exp=%0b", cyc, dec_valid, (e_dec != 2'b00)); end
            total++; if (jump !== m_jump) begin bad++; $display("FAIL rnd_jump cyc=%0d got=%0b exp=%0b", cyc, jump, m_jump); end
            total++; if (targ !== m_targ) begin bad++; $display("FAIL rnd_targ cyc=%0d got=%h exp=%h", cyc, targ, m_targ); end
            total++; if (busy !== e_busy) begin bad++; $display("FAIL rnd_busy cyc=%0d got=%0b exp=%0b", cyc, busy, e_busy); end
            m_jump = n_jump;
            m_targ = n_targ;
            @(posedge clk);
            #1;
        end
        quiet();
    endtask

    initial begin
        rst_n = 1'b0;
        quiet();
        test_reset();
        test_single_jump();
        test_loop_exit();
        test_nested();
        test_stall();
        test_flush();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
